// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared types and constants for the FIFO read-side sequencer.
// Used by fifo_rd_ctrl and fifo_rd_ctrl_to_cnt.
package fifo_rd_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int TO_W_DEF       = 6;
  localparam int FRM_CNT_W      = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POP       = 3'd1,
    LOAD      = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/fifo_rd_ctrl_to_cnt.sv
// Busy-wait timeout counter: cleared on LOAD, counts WAIT_BUSY cycles, and flags terminal
// count on the cycle whose increment reaches all-ones (2**TO_W-1 cycles after the clear).
module fifo_rd_ctrl_to_cnt
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int TO_W = TO_W_DEF
) (
  input  logic R_CLK,
  input  logic R_RST,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  logic [TO_W-1:0] r_cnt;
  logic [TO_W-1:0] w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + 1'b1;
  assign o_tc      = i_inc && (w_cnt_nxt == {TO_W{1'b1}});

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side sequencer: pops one FIFO word, holds it and hands it to the UART transmitter.
// Optional frame counter output FRM_CNT is built when FIFO_RD_CTRL_CNT_EN is defined.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TO_W       = TO_W_DEF
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  EN,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  Rinc,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_VLD,
  input  logic                  TX_BUSY,
  output logic                  ERR_TO
`ifdef FIFO_RD_CTRL_CNT_EN
  ,
  output logic [FRM_CNT_W-1:0]  FRM_CNT
`endif
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_rinc;
  logic                  r_tx_vld;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_err_to;
  logic                  w_to_clr;
  logic                  w_to_inc;
  logic                  w_to_tc;
  logic                  w_err_set;

  fifo_rd_ctrl_to_cnt #(
    .TO_W (TO_W)
  ) u_to_cnt (
    .R_CLK (R_CLK),
    .R_RST (R_RST),
    .i_clr (w_to_clr),
    .i_inc (w_to_inc),
    .o_tc  (w_to_tc)
  );

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_to_clr    = 1'b0;
    w_to_inc    = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (EN && !EMPTY && !TX_BUSY) begin
          w_state_nxt = POP;
        end
      end
      POP: begin
        w_state_nxt = LOAD;
      end
      LOAD: begin
        w_to_clr    = 1'b1;
        w_state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (TX_BUSY) begin
          w_state_nxt = WAIT_DONE;
        end else begin
          w_to_inc = 1'b1;
          if (w_to_tc) begin
            // Retry the held word; nothing new is popped.
            w_err_set   = 1'b1;
            w_state_nxt = LOAD;
          end
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Strobes are registered from the next-state decode so they are glitch-free.
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      r_state  <= IDLE;
      r_rinc   <= 1'b0;
      r_tx_vld <= 1'b0;
      r_err_to <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rinc   <= (w_state_nxt == POP);
      r_tx_vld <= (w_state_nxt == LOAD);
      if (w_err_set) begin
        r_err_to <= 1'b1;
      end
    end
  end

  // NOTE: the held word is a plain register, not a memory, so it takes a reset value
  // and the transmitter never sees an unknown word.
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      r_tx_data <= '0;
    end else if (r_state == POP) begin
      r_tx_data <= RD_DATA;
    end
  end

  assign Rinc    = r_rinc;
  assign TX_VLD  = r_tx_vld;
  assign TX_DATA = r_tx_data;
  assign ERR_TO  = r_err_to;

`ifdef FIFO_RD_CTRL_CNT_EN
  logic                 w_frm_done;
  logic [FRM_CNT_W-1:0] r_frm_cnt;

  assign w_frm_done = (r_state == WAIT_DONE) && !TX_BUSY;

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      r_frm_cnt <= '0;
    end else if (w_frm_done) begin
      r_frm_cnt <= r_frm_cnt + 1'b1;
    end
  end

  assign FRM_CNT = r_frm_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: FIFO and transmitter models, a timeline model of the
// sequencer, a per-cycle compare process and directed scenarios with literal expectations.
module tb_fifo_rd_ctrl;

  localparam int TOW      = 3;
  localparam int TO_LIMIT = (1 << TOW) - 1;

  logic       R_CLK   = 1'b0;
  logic       R_RST   = 1'b1;
  logic       EN      = 1'b0;
  logic       EMPTY   = 1'b1;
  logic [7:0] RD_DATA = 8'h00;
  logic       TX_BUSY = 1'b0;
  logic       Rinc;
  logic [7:0] TX_DATA;
  logic       TX_VLD;
  logic       ERR_TO;
`ifdef FIFO_RD_CTRL_CNT_EN
  logic [15:0] FRM_CNT;
  logic [15:0] frm_off = 16'h0000;
`endif

  fifo_rd_ctrl #(
    .DATA_WIDTH (8),
    .TO_W       (TOW)
  ) dut (
    .R_CLK   (R_CLK),
    .R_RST   (R_RST),
    .EN      (EN),
    .EMPTY   (EMPTY),
    .RD_DATA (RD_DATA),
    .Rinc    (Rinc),
    .TX_DATA (TX_DATA),
    .TX_VLD  (TX_VLD),
    .TX_BUSY (TX_BUSY),
    .ERR_TO  (ERR_TO)
`ifdef FIFO_RD_CTRL_CNT_EN
    ,
    .FRM_CNT (FRM_CNT)
`endif
  );

  always #5 R_CLK = ~R_CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO and transmitter environment ----------------
  logic [7:0] fifo_q[$];
  logic [7:0] vld_log[$];
  int         n_pops   = 0;
  bit         tx_never = 1'b0;
  int         tx_delay = 0;
  int         tx_hold  = 0;

  initial begin : env
    bit         rinc_s;
    bit         vld_s;
    logic [7:0] tmp;
    forever begin
      @(negedge R_CLK);
      rinc_s = Rinc;
      vld_s  = TX_VLD;
      if (vld_s) vld_log.push_back(TX_DATA);
      @(posedge R_CLK);
      #1;
      if (rinc_s) begin
        n_pops++;
        if (fifo_q.size() > 0) tmp = fifo_q.pop_front();
      end
      if (tx_hold > 0) tx_hold--;
      if (vld_s && !tx_never) begin
        tx_delay = 2;
      end else if (tx_delay > 0) begin
        tx_delay--;
        if (tx_delay == 0) tx_hold = 10;
      end
      TX_BUSY = (tx_hold > 0);
      EMPTY   = (fifo_q.size() == 0);
      RD_DATA = EMPTY ? 8'h00 : fifo_q[0];
    end
  end

  // ---------------- Timeline model of one frame ----------------
  logic        exp_rinc = 1'b0;
  logic        exp_vld  = 1'b0;
  logic        exp_err  = 1'b0;
  logic [7:0]  exp_data = 8'h00;
  logic [15:0] exp_frm  = 16'h0000;

  task automatic model_step(output bit ab);
    @(posedge R_CLK or negedge R_RST);
    ab = 1'b0;
    if (!R_RST) begin
      exp_rinc = 1'b0;
      exp_vld  = 1'b0;
      exp_err  = 1'b0;
      exp_data = 8'h00;
      exp_frm  = 16'h0000;
      ab       = 1'b1;
    end
  endtask

  task automatic model_frame();
    bit ab;
    int n;
    do model_step(ab); while (!(R_RST && EN && !EMPTY && !TX_BUSY));
    exp_rinc = 1'b1;
    model_step(ab);
    if (ab) return;
    exp_rinc = 1'b0;
    exp_data = RD_DATA;
    forever begin
      exp_vld = 1'b1;
      model_step(ab);
      if (ab) return;
      exp_vld = 1'b0;
      n = 0;
      do begin
        model_step(ab);
        if (ab) return;
        n++;
      end while (!TX_BUSY && n < TO_LIMIT);
      if (TX_BUSY) break;
      exp_err = 1'b1;
    end
    do begin
      model_step(ab);
      if (ab) return;
    end while (TX_BUSY);
    exp_frm = exp_frm + 16'd1;
  endtask

  initial forever model_frame();

  initial begin : compare
    forever begin
      @(negedge R_CLK);
      check("rinc", Rinc, exp_rinc);
      check("tx_vld", TX_VLD, exp_vld);
      check("tx_data", TX_DATA, exp_data);
      check("err_to", ERR_TO, exp_err);
      check("rinc_vld_excl", Rinc & TX_VLD, 0);
`ifdef FIFO_RD_CTRL_CNT_EN
      check("frm_cnt", FRM_CNT, exp_frm + frm_off);
`endif
    end
  end

  // ---------------- Helpers ----------------
  task automatic wait_drain(input string name);
    int quiet = 0;
    for (int i = 0; i < 400 && quiet < 3; i++) begin
      @(negedge R_CLK);
      if (fifo_q.size() == 0 && !TX_BUSY && tx_delay == 0 && tx_hold == 0 && !Rinc && !TX_VLD)
        quiet++;
      else
        quiet = 0;
    end
    check(name, 32'(quiet >= 3), 1);
  endtask

  task automatic wait_vld(input string name, output int cycles);
    cycles = 0;
    do begin
      @(negedge R_CLK);
      cycles++;
    end while (!TX_VLD && cycles < 60);
    check(name, TX_VLD, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- Directed scenarios ----------------
  initial begin : main
    int base;
    int gap;
    fifo_q.push_back(8'hA5);
    EN = 1'b1;
    #1 R_RST = 1'b0;

    // 1: outputs held low in reset, then pop one cycle after release, load the next.
    repeat (3) @(negedge R_CLK);
    check("t1_rst_rinc", Rinc, 0);
    check("t1_rst_vld", TX_VLD, 0);
    check("t1_rst_data", TX_DATA, 0);
    check("t1_rst_err", ERR_TO, 0);
    R_RST = 1'b1;
    @(negedge R_CLK);
    check("t1_rinc_c1", Rinc, 1);
    check("t1_vld_c1", TX_VLD, 0);
    @(negedge R_CLK);
    check("t1_rinc_c2", Rinc, 0);
    check("t1_vld_c2", TX_VLD, 1);
    check("t1_data_c2", TX_DATA, 8'hA5);
    wait_drain("t1_drain");

    // 2: three words, one pop per frame.
    base = n_pops;
    vld_log.delete();
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    wait_drain("t2_drain");
    check("t2_pops", n_pops - base, 3);
    check("t2_nvld", vld_log.size(), 3);
    if (vld_log.size() == 3) begin
      check("t2_word0", vld_log[0], 8'h11);
      check("t2_word1", vld_log[1], 8'h22);
      check("t2_word2", vld_log[2], 8'h33);
    end

    // 3: transmitter ignores the start strobe -> timeout after 7 wait cycles, retry same word.
    tx_never = 1'b1;
    base = n_pops;
    vld_log.delete();
    fifo_q.push_back(8'h5C);
    wait_vld("t3_first_vld", gap);
    check("t3_err_before", ERR_TO, 0);
    wait_vld("t3_retry_vld", gap);
    check("t3_retry_gap", gap, 8);
    check("t3_err_after", ERR_TO, 1);
    check("t3_retry_data", TX_DATA, 8'h5C);
    check("t3_pops", n_pops - base, 1);
    tx_never = 1'b0;
    wait_drain("t3_drain");
    check("t3_err_sticky", ERR_TO, 1);
    check("t3_pops_end", n_pops - base, 1);

    // 4: EN dropped mid-frame, frame completes and the rest waits for EN.
    base = n_pops;
    vld_log.delete();
    fifo_q.push_back(8'h41);
    fifo_q.push_back(8'h42);
    fifo_q.push_back(8'h43);
    gap = 0;
    do begin
      @(negedge R_CLK);
      gap++;
    end while (!TX_BUSY && gap < 60);
    check("t4_busy_seen", TX_BUSY, 1);
    @(negedge R_CLK);
    EN = 1'b0;
    repeat (30) @(negedge R_CLK);
    check("t4_hold_pops", n_pops - base, 1);
    check("t4_hold_left", fifo_q.size(), 2);
    EN = 1'b1;
    wait_drain("t4_drain");
    check("t4_pops", n_pops - base, 3);
    if (vld_log.size() == 3) begin
      check("t4_word1", vld_log[1], 8'h42);
      check("t4_word2", vld_log[2], 8'h43);
    end else begin
      check("t4_nvld", vld_log.size(), 3);
    end

    // 5: asynchronous reset while waiting for busy aborts the frame.
    tx_never = 1'b1;
    base = n_pops;
    fifo_q.push_back(8'h77);
    wait_vld("t5_vld", gap);
    repeat (3) @(negedge R_CLK);
    #2 R_RST = 1'b0;
    #1;
    check("t5_rst_rinc", Rinc, 0);
    check("t5_rst_vld", TX_VLD, 0);
    check("t5_rst_err", ERR_TO, 0);
    check("t5_rst_data", TX_DATA, 0);
    @(negedge R_CLK);
    @(negedge R_CLK);
    R_RST = 1'b1;
    repeat (10) @(negedge R_CLK);
    check("t5_no_repop", n_pops - base, 1);
    tx_never = 1'b0;
    vld_log.delete();
    fifo_q.push_back(8'h88);
    wait_drain("t5_drain");
    check("t5_restart_pops", n_pops - base, 2);
    if (vld_log.size() > 0) check("t5_restart_word", vld_log[0], 8'h88);
    else check("t5_restart_nvld", vld_log.size(), 1);
    check("t5_err_clear", ERR_TO, 0);

`ifdef FIFO_RD_CTRL_CNT_EN
    // 6: frame counter wraps after preload.
    #2;
    frm_off = 16'hFFFE - exp_frm;
    force dut.r_frm_cnt = 16'hFFFE;
    @(posedge R_CLK);
    #1 release dut.r_frm_cnt;
    fifo_q.push_back(8'hC1);
    fifo_q.push_back(8'hC2);
    wait_drain("t6_drain");
    check("t6_frm_wrap", FRM_CNT, 16'h0000);
`endif

    repeat (2) @(negedge R_CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
